// File: rtl/cont_deca_incr_pkg.sv
// Shared constants and types for the two-digit BCD up counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cont_deca_incr_pkg;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Largest value of a decimal digit; default moduli are DEC_MAX+1.
  localparam int DEC_MAX = 9;

  // One BCD digit.
  typedef logic [DIGIT_W-1:0] bcd_t;

endpackage : cont_deca_incr_pkg

// File: rtl/bcd_digit.sv
// One modulo-MOD counting digit with synchronous load-to-max and carry out.
// Latency: q updates one posedge after load/en; co is combinational.
// Backpressure: none; en is sampled every posedge, clear acts immediately.
module bcd_digit
  import cont_deca_incr_pkg::*;
#(
  parameter int W   = DIGIT_W,
  parameter int MOD = DEC_MAX + 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         co
);

  // Terminal value of this digit (MOD-1), sized to the digit width.
  localparam logic [W-1:0] MAX_V = W'(MOD - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next state: load beats enable; an enabled digit at or beyond its terminal
  // value returns to zero, which also recovers forced out-of-range values.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = MAX_V;
    end else if (en) begin
      if (q_q >= MAX_V) begin
        q_d = '0;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
  end

  // Digit register; clear zeroes it at once, independent of the clock.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Carry only on a genuine terminal value, so an out-of-range digit never carries.
  assign co = en & (q_q == MAX_V);

endmodule : bcd_digit

// File: rtl/cont_deca_incr.sv
// Two-digit synchronous BCD up counter (00..MOD_T*MOD_U-1) with cascade terminal count.
// Latency: digits update one posedge after in/preset; tc is combinational from state and in.
// Backpressure: none; in is a plain count enable sampled every posedge.
module cont_deca_incr
  import cont_deca_incr_pkg::DEC_MAX;
#(
  parameter int DIGIT_W = cont_deca_incr_pkg::DIGIT_W,
  parameter int MOD_U   = DEC_MAX + 1,
  parameter int MOD_T   = DEC_MAX + 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               preset,
  input  logic               in,
  output logic [DIGIT_W-1:0] units,
  output logic [DIGIT_W-1:0] tens,
  output logic               tc
);

  logic units_co;
  logic tens_co;

  // Both digits share clk, so every state bit moves on the same edge; the
  // units carry is a synchronous enable for tens, not a ripple clock.
  bcd_digit #(
    .W   (DIGIT_W),
    .MOD (MOD_U)
  ) u_units (
    .clk   (clk),
    .clear (clear),
    .load  (preset),
    .en    (in),
    .q     (units),
    .co    (units_co)
  );

  bcd_digit #(
    .W   (DIGIT_W),
    .MOD (MOD_T)
  ) u_tens (
    .clk   (clk),
    .clear (clear),
    .load  (preset),
    .en    (units_co),
    .q     (tens),
    .co    (tens_co)
  );

  // Terminal count for cascading: the whole counter is about to wrap.
  assign tc = tens_co;

endmodule : cont_deca_incr

// File: tb/tb_cont_deca_incr.sv
// Self-checking bench for cont_deca_incr: vector table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cont_deca_incr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default decimal counter 00..99
  logic       clear_a, preset_a, in_a;
  logic [3:0] units_a, tens_a;
  logic       tc_a;

  // DUT B: seconds-style MOD_U=6, MOD_T=4
  logic       clear_b, preset_b, in_b;
  logic [3:0] units_b, tens_b;
  logic       tc_b;

  int tests = 0;
  int fails = 0;

  cont_deca_incr dut_a (
    .clk    (clk),
    .clear  (clear_a),
    .preset (preset_a),
    .in     (in_a),
    .units  (units_a),
    .tens   (tens_a),
    .tc     (tc_a)
  );

  cont_deca_incr #(.DIGIT_W(4), .MOD_U(6), .MOD_T(4)) dut_b (
    .clk    (clk),
    .clear  (clear_b),
    .preset (preset_b),
    .in     (in_b),
    .units  (units_b),
    .tens   (tens_b),
    .tc     (tc_b)
  );

  typedef struct {
    logic clr;
    logic pre;
    logic inc;
    int   u;
    int   t;
    int   tc;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Check DUT A against a count value n (decimal 0..99) and expected tc
  task automatic chk_a(input string name, input int n, input int exp_tc);
    chk({name, " units"}, int'(units_a), n % 10);
    chk({name, " tens"},  int'(tens_a),  n / 10);
    chk({name, " tc"},    int'(tc_a),    exp_tc);
  endtask

  task automatic chk_b(input string name, input int n, input int exp_tc);
    chk({name, " units"}, int'(units_b), n % 6);
    chk({name, " tens"},  int'(tens_b),  n / 6);
    chk({name, " tc"},    int'(tc_b),    exp_tc);
  endtask

  // Called at negedge: drive A inputs, take one posedge, return at next negedge
  task automatic step_a(input logic c, input logic p, input logic i);
    clear_a = c; preset_a = p; in_a = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_b(input logic c, input logic p, input logic i);
    clear_b = c; preset_b = p; in_b = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n_a, n_b, tc_cnt;
    logic ca, pa, ia, cb, pb, ib;

    // ---- vector table ----
    vecs[0] = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
    for (int k = 1; k <= 12; k++) vecs[k] = '{1'b0, 1'b0, 1'b1, k % 10, k / 10, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 9, 9, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 9, 9, 0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 9, 9, 0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};

    clear_a = 1'b1; preset_a = 1'b0; in_a = 1'b0;
    clear_b = 1'b1; preset_b = 1'b0; in_b = 1'b0;
    #1;
    chk_a("reset A", 0, 0);
    chk_b("reset B", 0, 0);
    @(negedge clk);

    for (int v = 0; v < 18; v++) begin
      step_a(vecs[v].clr, vecs[v].pre, vecs[v].inc);
      chk($sformatf("vec%0d units", v), int'(units_a), vecs[v].u);
      chk($sformatf("vec%0d tens", v),  int'(tens_a),  vecs[v].t);
      chk($sformatf("vec%0d tc", v),    int'(tc_a),    vecs[v].tc);
    end

    // ---- hold at 37 ----
    step_a(1'b1, 1'b0, 1'b0);
    chk_a("clear before 37", 0, 0);
    for (int k = 0; k < 37; k++) step_a(1'b0, 1'b0, 1'b1);
    chk_a("reach 37", 37, 0);
    for (int k = 0; k < 5; k++) begin
      step_a(1'b0, 1'b0, 1'b0);
      chk_a($sformatf("hold37 e%0d", k), 37, 0);
    end
    step_a(1'b0, 1'b0, 1'b1);
    chk_a("resume 38", 38, 0);

    // ---- asynchronous clear at 54 ----
    for (int k = 0; k < 16; k++) step_a(1'b0, 1'b0, 1'b1);
    chk_a("reach 54", 54, 0);
    clear_a = 1'b1;
    #1;
    chk_a("async clear", 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk_a($sformatf("clear held e%0d", k), 0, 0);
    end

    // ---- full 100-edge wrap ----
    clear_a = 1'b0; in_a = 1'b1; preset_a = 1'b0;
    tc_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (tc_a === 1'b1) tc_cnt++;
      chk_a($sformatf("run100 k%0d", k), k, (k == 99) ? 1 : 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk_a("run100 wrap", 0, 0);
    chk("run100 tc pulses", tc_cnt, 1);

    // ---- seconds-style instance ----
    step_b(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      chk_b($sformatf("mod6x4 k%0d", k), k % 24, ((k % 24) == 23) ? 1 : 0);
      step_b(1'b0, 1'b0, 1'b1);
    end
    chk_b("mod6x4 after wrap", 1, 0);
    step_b(1'b0, 1'b1, 1'b0);
    chk_b("mod6x4 preset", 23, 0);

    // ---- random vs behavioural model ----
    step_a(1'b1, 1'b0, 1'b0);
    step_b(1'b1, 1'b0, 1'b0);
    n_a = 0;
    n_b = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ca = ($urandom_range(0, 31) == 0);
      pa = ($urandom_range(0, 19) == 0);
      ia = ($urandom_range(0, 3) != 0);
      cb = ($urandom_range(0, 31) == 0);
      pb = ($urandom_range(0, 19) == 0);
      ib = ($urandom_range(0, 3) != 0);
      clear_a = ca; preset_a = pa; in_a = ia;
      clear_b = cb; preset_b = pb; in_b = ib;
      #1;
      if (ca) n_a = 0;
      if (cb) n_b = 0;
      chk_a($sformatf("rnd A c%0d pre", cyc), n_a, (ia && !ca && n_a == 99) ? 1 : 0);
      chk_b($sformatf("rnd B c%0d pre", cyc), n_b, (ib && !cb && n_b == 23) ? 1 : 0);
      @(posedge clk);
      if (ca)      n_a = 0;
      else if (pa) n_a = 99;
      else if (ia) n_a = (n_a + 1) % 100;
      if (cb)      n_b = 0;
      else if (pb) n_b = 23;
      else if (ib) n_b = (n_b + 1) % 24;
      @(negedge clk);
    end
    #1;
    chk_a("rnd A final", n_a, (in_a && !clear_a && n_a == 99) ? 1 : 0);
    chk_b("rnd B final", n_b, (in_b && !clear_b && n_b == 23) ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cont_deca_incr
